// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared constants and types for the vertical timing stage.
// Contents: default frame geometry (scanlines per frame, visible lines, VSYNC position and length),
//           the 9-bit scanline type, and the state encoding used by the interrupt latches.
package video_timing_pkg;

   localparam int V_TOTAL_DEF     = 262;
   localparam int V_ACTIVE_DEF    = 240;
   localparam int VSYNC_START_DEF = 244;
   localparam int VSYNC_LEN_DEF   = 3;

   typedef logic [8:0] vline_t;

   typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_t;

endpackage

// File: rtl/irq_latch.sv
// irq_latch: level interrupt request that is set by an event pulse and cleared by a CPU acknowledge.
// Ports: clk100 system clock; rst_b async active-low reset; set event pulse; ack clear pulse;
//        irq_b active-low pending flag (1 out of reset).
// A set arriving in the same cycle as an ack takes priority, so no event is lost.
module irq_latch
   import video_timing_pkg::*;
(
   input  logic clk100,
   input  logic rst_b,
   input  logic set,
   input  logic ack,
   output logic irq_b
);

   irq_state_t r_state;
   irq_state_t w_next;

   always_ff @(posedge clk100 or negedge rst_b)
      if (!rst_b) r_state <= IRQ_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (set)      w_next = IRQ_PEND;
      else if (ack) w_next = IRQ_IDLE;
   end

   assign irq_b = (r_state == IRQ_IDLE);

endmodule

// File: rtl/vertical_timing_gen.sv
// vertical_timing_gen: scanline counter with VBLANK/VSYNC windows, frame pulse and VBLANK interrupt.
// Ports: clk100 system clock; rst_b async active-low reset;
//        MCKR, HSYNC sampled as data (never clocks); vint_ack clears VINT_b;
//        vcount scanline number; VBLANK_b, VSYNC_b active-low windows; VINT_b pending VBLANK irq;
//        frame_start one-cycle pulse on wrap to line 0.
// Build option VTIMING_SCANLINE_IRQ_EN adds irq_line, scan_ack and SCAN_INT_b (scanline compare irq).
module vertical_timing_gen
   import video_timing_pkg::*;
#(
   parameter int VW          = 9,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int VSYNC_START = VSYNC_START_DEF,
   parameter int VSYNC_LEN   = VSYNC_LEN_DEF
) (
   input  logic          clk100,
   input  logic          rst_b,
   input  logic          MCKR,
   input  logic          HSYNC,
   input  logic          vint_ack,
   output logic [VW-1:0] vcount,
   output logic          VBLANK_b,
   output logic          VSYNC_b,
   output logic          VINT_b,
   output logic          frame_start
`ifdef VTIMING_SCANLINE_IRQ_EN
   ,
   input  logic [VW-1:0] irq_line,
   input  logic          scan_ack,
   output logic          SCAN_INT_b
`endif
);

   localparam logic [VW-1:0] L_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] L_ACTIVE = VW'(V_ACTIVE);
   localparam logic [VW-1:0] L_VS_BEG = VW'(VSYNC_START);
   // One bit wider so a window ending exactly at 2**VW still compares correctly
   localparam logic [VW:0]   L_VS_END = (VW+1)'(VSYNC_START + VSYNC_LEN);

   if (V_TOTAL > 2**VW) begin : g_bad_total
      $error("V_TOTAL does not fit in vcount");
   end
   if (V_ACTIVE >= V_TOTAL) begin : g_bad_active
      $error("V_ACTIVE must be below V_TOTAL");
   end
   if (VSYNC_START + VSYNC_LEN > V_TOTAL) begin : g_bad_vsync
      $error("VSYNC window runs past V_TOTAL");
   end

   logic          r_mckr_q;
   logic          r_hsync_q;
   logic          w_mckr_rise;
   logic          w_line_tick;
   logic [VW-1:0] w_vnext;

   assign w_mckr_rise = MCKR & ~r_mckr_q;
   // HSYNC is only looked at on MCKR rises, so glitches between rises are invisible
   assign w_line_tick = w_mckr_rise & HSYNC & ~r_hsync_q;
   assign w_vnext     = !w_line_tick ? vcount : (vcount == L_LAST) ? '0 : vcount + 1'b1;

   // hsync_q resets high so an HSYNC already high at release is not seen as a rise
   always_ff @(posedge clk100 or negedge rst_b)
      if (!rst_b) begin
         r_mckr_q    <= 1'b0;
         r_hsync_q   <= 1'b1;
         vcount      <= '0;
         VBLANK_b    <= 1'b1;
         VSYNC_b     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         r_mckr_q    <= MCKR;
         if (w_mckr_rise) r_hsync_q <= HSYNC;
         vcount      <= w_vnext;
         VBLANK_b    <= ~(w_vnext >= L_ACTIVE);
         VSYNC_b     <= ~((w_vnext >= L_VS_BEG) && ({1'b0, w_vnext} < L_VS_END));
         frame_start <= w_line_tick && (vcount == L_LAST);
      end

   irq_latch u_vint (
      .clk100 (clk100),
      .rst_b  (rst_b),
      .set    (w_line_tick && (w_vnext == L_ACTIVE)),
      .ack    (vint_ack),
      .irq_b  (VINT_b)
   );

`ifdef VTIMING_SCANLINE_IRQ_EN
   // w_vnext never reaches V_TOTAL, so an out-of-range irq_line simply never matches
   irq_latch u_scan (
      .clk100 (clk100),
      .rst_b  (rst_b),
      .set    (w_line_tick && (w_vnext == irq_line)),
      .ack    (scan_ack),
      .irq_b  (SCAN_INT_b)
   );
`endif

endmodule

// File: tb/tb_vertical_timing_gen.sv
// tb_vertical_timing_gen: randomized line timing checked against a line-count reference model.
// Ports: none (top-level bench); drives clk100, rst_b, MCKR, HSYNC, vint_ack (and scanline irq inputs
//        when VTIMING_SCANLINE_IRQ_EN is defined).
module tb_vertical_timing_gen;

   localparam int TOTAL  = 262;
   localparam int ACTIVE = 240;
   localparam int VS0    = 244;
   localparam int VS1    = 247;

   logic       clk100   = 1'b0;
   logic       rst_b    = 1'b1;
   logic       MCKR     = 1'b0;
   logic       HSYNC    = 1'b1;
   logic       vint_ack = 1'b0;
   logic [8:0] vcount;
   logic       VBLANK_b;
   logic       VSYNC_b;
   logic       VINT_b;
   logic       frame_start;
`ifdef VTIMING_SCANLINE_IRQ_EN
   logic [8:0] irq_line = 9'd300;
   logic       scan_ack = 1'b0;
   logic       SCAN_INT_b;
   bit         exp_scan;
`endif

   int n_vec, n_err, fs_cnt, exp_frames, exp_line, mck_div;
   bit exp_vint;

   vertical_timing_gen dut (
      .clk100      (clk100),
      .rst_b       (rst_b),
      .MCKR        (MCKR),
      .HSYNC       (HSYNC),
      .vint_ack    (vint_ack),
      .vcount      (vcount),
      .VBLANK_b    (VBLANK_b),
      .VSYNC_b     (VSYNC_b),
      .VINT_b      (VINT_b),
      .frame_start (frame_start)
`ifdef VTIMING_SCANLINE_IRQ_EN
      ,
      .irq_line    (irq_line),
      .scan_ack    (scan_ack),
      .SCAN_INT_b  (SCAN_INT_b)
`endif
   );

   always #5 clk100 = ~clk100;

   // MCKR = clk100/14: 7 cycles high, 7 low, changed on falling clk100 edges
   initial forever begin
      @(negedge clk100);
      mck_div = (mck_div == 13) ? 0 : mck_div + 1;
      MCKR = (mck_div < 7);
   end

   always @(negedge clk100) if (frame_start === 1'b1) fs_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit fs);
      chk($sformatf("%s.L%0d.vcount", tag, exp_line), 32'(vcount), 32'(exp_line));
      chk($sformatf("%s.L%0d.VBLANK_b", tag, exp_line), 32'(VBLANK_b), 32'(exp_line < ACTIVE));
      chk($sformatf("%s.L%0d.VSYNC_b", tag, exp_line), 32'(VSYNC_b), 32'(!(exp_line >= VS0 && exp_line < VS1)));
      chk($sformatf("%s.L%0d.VINT_b", tag, exp_line), 32'(VINT_b), 32'(!exp_vint));
      chk($sformatf("%s.L%0d.frame_start", tag, exp_line), 32'(frame_start), 32'(fs));
`ifdef VTIMING_SCANLINE_IRQ_EN
      chk($sformatf("%s.L%0d.SCAN_INT_b", tag, exp_line), 32'(SCAN_INT_b), 32'(!exp_scan));
`endif
   endtask

   // One scanline: HSYNC rises while MCKR is low, stays high for hi MCKR rises, low for lo rises.
   task automatic line_step(input bit ack_tick, input bit ack_mid, input bit sack_mid);
      int hi, lo;
      hi = $urandom_range(1, 2);
      lo = $urandom_range(1, 2);
      @(negedge MCKR);
      HSYNC = 1'b1;
      @(posedge MCKR);
      vint_ack = ack_tick;
      @(negedge clk100);
      vint_ack = 1'b0;
      exp_line = (exp_line + 1) % TOTAL;
      if (exp_line == 0) exp_frames++;
      if (exp_line == ACTIVE) exp_vint = 1'b1;
      else if (ack_tick) exp_vint = 1'b0;
`ifdef VTIMING_SCANLINE_IRQ_EN
      if (exp_line == int'(irq_line)) exp_scan = 1'b1;
`endif
      check_all("tick", exp_line == 0);
      if (ack_mid) begin
         vint_ack = 1'b1;
         @(negedge clk100);
         vint_ack = 1'b0;
         exp_vint = 1'b0;
         @(negedge clk100);
         chk($sformatf("ack.L%0d.VINT_b", exp_line), 32'(VINT_b), 32'(!exp_vint));
      end
`ifdef VTIMING_SCANLINE_IRQ_EN
      if (sack_mid) begin
         scan_ack = 1'b1;
         @(negedge clk100);
         scan_ack = 1'b0;
         exp_scan = 1'b0;
         @(negedge clk100);
         chk($sformatf("sack.L%0d.SCAN_INT_b", exp_line), 32'(SCAN_INT_b), 32'(!exp_scan));
      end
`else
      if (sack_mid) repeat (2) @(negedge clk100);
`endif
      repeat (hi) @(negedge MCKR);
      HSYNC = 1'b0;
      repeat (lo) @(negedge MCKR);
      chk("frame_start_cycles", 32'(fs_cnt), 32'(exp_frames));
   endtask

   initial begin
      // Reset released with HSYNC already high: no tick
      #2 rst_b = 1'b0;
      repeat (4) @(negedge clk100);
      rst_b = 1'b1;
      repeat (3) @(negedge MCKR);
      check_all("reset", 1'b0);
      HSYNC = 1'b0;
      // Full frame with no acknowledge: VINT_b falls at 240 and stays low past the wrap
      for (int k = 1; k <= TOTAL; k++) line_step(1'b0, 1'b0, 1'b0);
`ifdef VTIMING_SCANLINE_IRQ_EN
      irq_line = 9'd100;
`endif
      // HSYNC held high across 500 MCKR rises counts once
      @(negedge MCKR);
      HSYNC = 1'b1;
      @(posedge MCKR);
      @(negedge clk100);
      exp_line = exp_line + 1;
      chk("hold.first", 32'(vcount), 32'(exp_line));
      repeat (500) @(negedge MCKR);
      HSYNC = 1'b0;
      @(negedge MCKR);
      chk("hold.after", 32'(vcount), 32'(exp_line));
      // HSYNC pulse entirely between MCKR rises is ignored
      @(negedge MCKR);
      @(negedge clk100);
      HSYNC = 1'b1;
      repeat (3) @(negedge clk100);
      HSYNC = 1'b0;
      @(posedge MCKR);
      repeat (2) @(negedge clk100);
      chk("pulse", 32'(vcount), 32'(exp_line));
      // Advance to line 120, then assert reset asynchronously mid-cycle
      while (exp_line < 120) line_step(1'b0, 1'b0, 1'b0);
      rst_b = 1'b0;
      exp_line = 0;
      exp_vint = 1'b0;
`ifdef VTIMING_SCANLINE_IRQ_EN
      exp_scan = 1'b0;
`endif
      #1;
      check_all("async_rst", 1'b0);
      HSYNC = 1'b1;
      repeat (3) @(negedge clk100);
      rst_b = 1'b1;
      repeat (3) @(negedge MCKR);
      check_all("release", 1'b0);
      HSYNC = 1'b0;
      // Frame with ack coincident with set at 240, ack at 250, random acks elsewhere
      for (int k = 1; k <= TOTAL; k++)
         line_step(k == ACTIVE, (k == 250) || ($urandom_range(0, 7) == 0), k == 105);
      line_step(1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
